pc_fleet_responder: RTL and testbench

//  Computer-side end of the Battleship shot exchange: places the PC fleet pseudo-randomly
//  and answers each player shot with hit/miss. Player cursor logic is the initiator;

---
 rtl/pc_fleet_responder_pkg.sv | 27 ++
 rtl/pc_fleet_responder_if.sv | 21 ++
 rtl/pc_fleet_responder_lfsr8.sv | 19 +
 rtl/pc_fleet_responder.sv | 139 +++++++++++++
 tb/tb_pc_fleet_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fleet_responder_pkg.sv
// Shared types and helpers for the computer-side Battleship responder.
package pc_fleet_responder_pkg;

  localparam int GRID_N    = 5;
  localparam int MAX_SHIPS = 5;

  typedef enum logic [2:0] {IDLE, PLACE, READY, CHECK, RESP, DONE} state_t;

  typedef struct packed {
    logic hit;
    logic rpt;
    logic invalid;
  } resp_flags_t;

  function automatic int unsigned cell_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    return i * n + j;
  endfunction

  // A zero-ship fleet would end the game before it starts, so it becomes one ship.
  function automatic logic [2:0] clamp_ships(input logic [2:0] n, input logic [2:0] max_n);
    if (n == 3'd0) return 3'd1;
    if (n > max_n) return max_n;
    return n;
  endfunction

endpackage

// File: rtl/pc_fleet_responder_if.sv
// Shot request / response handshake between the player cursor (master) and the PC fleet.
interface pc_fleet_responder_if;
  logic       shot_valid;
  logic [2:0] shot_i;
  logic [2:0] shot_j;
  logic       shot_ready;
  logic       resp_valid;
  logic       resp_hit;
  logic       resp_repeat;
  logic       resp_invalid;

  modport master (
    output shot_valid, shot_i, shot_j,
    input  shot_ready, resp_valid, resp_hit, resp_repeat, resp_invalid
  );

  modport slave (
    input  shot_valid, shot_i, shot_j,
    output shot_ready, resp_valid, resp_hit, resp_repeat, resp_invalid
  );
endinterface

// File: rtl/pc_fleet_responder_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) with load-on-reset seed.
module pc_fleet_responder_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/pc_fleet_responder.sv
// Computer-side Battleship responder: random fleet placement, shot classification,
// remaining-ship tracking and ship/shot maps for display.
module pc_fleet_responder #(
  parameter int         GRID_N    = pc_fleet_responder_pkg::GRID_N,
  parameter int         MAX_SHIPS = pc_fleet_responder_pkg::MAX_SHIPS,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        place_start,
  input  logic [2:0]                  num_ships,
  pc_fleet_responder_if.slave         shot_if,
  output logic                        fleet_ready,
  output logic [2:0]                  ships_left,
  output logic                        all_sunk,
  output logic [GRID_N*GRID_N-1:0]    ship_map,
  output logic [GRID_N*GRID_N-1:0]    shot_map
);
  import pc_fleet_responder_pkg::*;

  localparam int         CELLS    = GRID_N * GRID_N;
  localparam int         IDX_W    = $clog2(CELLS);
  localparam logic [2:0] GRID_LIM = 3'(GRID_N);
  localparam logic [2:0] MAX_LIM  = 3'(MAX_SHIPS);

  state_t           state;
  logic [7:0]       lfsr;
  logic             lfsr_unused;
  logic [2:0]       target;
  logic [2:0]       lat_i;
  logic [2:0]       lat_j;
  logic             shot_ready_r;
  logic             resp_valid_r;
  resp_flags_t      resp_r;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] chk_idx;
  logic             cand_free;
  resp_flags_t      chk;

  pc_fleet_responder_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .state (lfsr)
  );

  assign cand        = lfsr[IDX_W-1:0];
  assign lfsr_unused = ^lfsr[7:IDX_W];

  always_comb begin
    cand_free = 1'b0;
    chk_idx   = IDX_W'(cell_idx(32'(lat_i), 32'(lat_j), 32'(GRID_N)));
    chk       = '0;
    if (32'(cand) < 32'(CELLS)) cand_free = !ship_map[cand];
    // Classification priority: off-board, then already fired on, then hit.
    chk.invalid = (lat_i >= GRID_LIM) || (lat_j >= GRID_LIM);
    chk.rpt     = !chk.invalid && shot_map[chk_idx];
    chk.hit     = !chk.invalid && !chk.rpt && ship_map[chk_idx];
  end

  assign shot_if.shot_ready   = shot_ready_r;
  assign shot_if.resp_valid   = resp_valid_r;
  assign shot_if.resp_hit     = resp_r.hit;
  assign shot_if.resp_repeat  = resp_r.rpt;
  assign shot_if.resp_invalid = resp_r.invalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      target       <= '0;
      lat_i        <= '0;
      lat_j        <= '0;
      shot_ready_r <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_r       <= '0;
      fleet_ready  <= 1'b0;
      ships_left   <= '0;
      all_sunk     <= 1'b0;
      ship_map     <= '0;
      shot_map     <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      // A new game request overrides whatever is in flight, including a pending shot.
      if (place_start) begin
        ship_map     <= '0;
        shot_map     <= '0;
        ships_left   <= '0;
        fleet_ready  <= 1'b0;
        all_sunk     <= 1'b0;
        shot_ready_r <= 1'b0;
        resp_r       <= '0;
        target       <= clamp_ships(num_ships, MAX_LIM);
        state        <= PLACE;
      end else begin
        case (state)
          IDLE: ;
          PLACE: begin
            if (cand_free) begin
              ship_map[cand] <= 1'b1;
              ships_left     <= ships_left + 3'd1;
              if (3'(ships_left + 3'd1) == target) begin
                fleet_ready  <= 1'b1;
                shot_ready_r <= 1'b1;
                state        <= READY;
              end
            end
          end
          READY: begin
            if (shot_if.shot_valid) begin
              lat_i        <= shot_if.shot_i;
              lat_j        <= shot_if.shot_j;
              shot_ready_r <= 1'b0;
              state        <= CHECK;
            end
          end
          CHECK: begin
            resp_r       <= chk;
            resp_valid_r <= 1'b1;
            if (!chk.invalid && !chk.rpt) shot_map[chk_idx] <= 1'b1;
            if (chk.hit && ships_left != 3'd0) ships_left <= ships_left - 3'd1;
            state <= RESP;
          end
          RESP: begin
            if (ships_left == 3'd0) begin
              all_sunk <= 1'b1;
              state    <= DONE;
            end else begin
              shot_ready_r <= 1'b1;
              state        <= READY;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fleet_responder.sv
// Randomised scoreboard bench for pc_fleet_responder with a board-level reference model.
module tb_pc_fleet_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        place_start;
  logic [2:0]  num_ships;
  logic        fleet_ready;
  logic [2:0]  ships_left;
  logic        all_sunk;
  logic [24:0] ship_map;
  logic [24:0] shot_map;

  pc_fleet_responder_if bus ();

  pc_fleet_responder dut (
    .clk         (clk),
    .rst         (rst),
    .place_start (place_start),
    .num_ships   (num_ships),
    .shot_if     (bus.slave),
    .fleet_ready (fleet_ready),
    .ships_left  (ships_left),
    .all_sunk    (all_sunk),
    .ship_map    (ship_map),
    .shot_map    (shot_map)
  );

  typedef struct {
    logic        hit;
    logic        rpt;
    logic        inv;
    logic [2:0]  left;
    logic [24:0] smap;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [7:0]  m_lfsr;
  logic [24:0] m_ships;
  logic [24:0] m_shots;
  int          m_left;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // The reference LFSR free-runs exactly like the placement source is specified to.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr = 8'hA5;
    else     m_lfsr = lfsr_step(m_lfsr);
  end

  // Fleet = the first t distinct on-board cells drawn from the LFSR stream.
  function automatic logic [24:0] fleet_from(input logic [7:0] s0, input int t);
    logic [24:0] m;
    logic [7:0]  s;
    int          placed;
    m = '0; s = s0; placed = 0;
    for (int k = 0; k < 1000 && placed < t; k++) begin
      if (s[4:0] < 5'd25 && !m[s[4:0]]) begin
        m[s[4:0]] = 1'b1;
        placed++;
      end
      s = lfsr_step(s);
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("resp_hit",     32'(bus.resp_hit),     32'(mon_e.hit));
        check("resp_repeat",  32'(bus.resp_repeat),  32'(mon_e.rpt));
        check("resp_invalid", 32'(bus.resp_invalid), 32'(mon_e.inv));
        check("resp_latency", 32'(cyc - mon_e.cyc),  32'd1);
        check("resp_ships_left", 32'(ships_left),    32'(mon_e.left));
        check("resp_shot_map",   32'(shot_map),      32'(mon_e.smap));
        check("resp_ship_map",   32'(ship_map),      32'(m_ships));
      end
    end
  end

  task automatic place(input logic [2:0] n, input bit with_shot);
    int t;
    bit ok;
    @(negedge clk);
    place_start = 1'b1;
    num_ships   = n;
    if (with_shot) begin
      bus.shot_valid = 1'b1;
      bus.shot_i     = 3'd0;
      bus.shot_j     = 3'd0;
    end
    @(posedge clk);
    #1;
    place_start    = 1'b0;
    bus.shot_valid = 1'b0;
    t       = (n == 3'd0) ? 1 : (n > 3'd5) ? 5 : int'(n);
    m_ships = fleet_from(m_lfsr, t);
    m_shots = '0;
    m_left  = t;
    check("place_clears_left",  32'(ships_left),     32'd0);
    check("place_clears_ready", 32'(bus.shot_ready), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 256 && !ok; k++) begin
      @(negedge clk);
      if (fleet_ready) ok = 1'b1;
    end
    check("fleet_ready_timeout", 32'(ok), 32'd1);
    check("fleet_ship_map",  32'(ship_map),            32'(m_ships));
    check("fleet_popcount",  32'($countones(ship_map)), 32'(t));
    check("fleet_ships_left", 32'(ships_left),          32'(t));
    check("fleet_shot_map",  32'(shot_map),            32'd0);
    check("fleet_all_sunk",  32'(all_sunk),            32'd0);
    check("fleet_shot_ready", 32'(bus.shot_ready),     32'd1);
  endtask

  task automatic shoot(input logic [2:0] i, input logic [2:0] j);
    bit   ok;
    exp_t e;
    int   idx;
    ok = 1'b0;
    @(negedge clk);
    bus.shot_valid = 1'b1;
    bus.shot_i     = i;
    bus.shot_j     = j;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.shot_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.shot_valid = 1'b0;
    if (!ok) begin
      check("shot_accept_timeout", 32'd0, 32'd1);
      return;
    end
    e.inv = (i >= 3'd5) || (j >= 3'd5);
    e.rpt = 1'b0;
    e.hit = 1'b0;
    if (!e.inv) begin
      idx   = int'(i) * 5 + int'(j);
      e.rpt = m_shots[idx];
      e.hit = !e.rpt && m_ships[idx];
      m_shots[idx] = 1'b1;
      if (e.hit) m_left--;
    end
    e.left = 3'(m_left);
    e.smap = m_shots;
    e.cyc  = cyc;
    q.push_back(e);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      check("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    if (m_left == 0) begin
      @(negedge clk);
      @(negedge clk);
      check("all_sunk_set",      32'(all_sunk),       32'd1);
      check("done_shot_ready",   32'(bus.shot_ready), 32'd0);
      check("done_ships_left",   32'(ships_left),     32'd0);
    end
  endtask

  task automatic random_until_sunk(input int max_shots);
    for (int n = 0; n < max_shots && m_left > 0; n++)
      shoot(3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)));
    for (int idx = 0; idx < 25; idx++)
      if (m_left > 0 && m_ships[idx] && !m_shots[idx]) shoot(3'(idx / 5), 3'(idx % 5));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_ship;
    int first_miss;
    rst            = 1'b1;
    place_start    = 1'b0;
    num_ships      = 3'd0;
    bus.shot_valid = 1'b0;
    bus.shot_i     = 3'd0;
    bus.shot_j     = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_fleet_ready", 32'(fleet_ready),      32'd0);
    check("rst_ships_left",  32'(ships_left),       32'd0);
    check("rst_all_sunk",    32'(all_sunk),         32'd0);
    check("rst_ship_map",    32'(ship_map),         32'd0);
    check("rst_shot_map",    32'(shot_map),         32'd0);
    check("rst_shot_ready",  32'(bus.shot_ready),   32'd0);
    check("rst_resp_valid",  32'(bus.resp_valid),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_shot_ready", 32'(bus.shot_ready), 32'd0);

    place(3'd3, 1'b0);
    first_ship = -1;
    first_miss = -1;
    for (int idx = 24; idx >= 0; idx--) begin
      if (m_ships[idx])  first_ship = idx;
      if (!m_ships[idx]) first_miss = idx;
    end
    shoot(3'(first_ship / 5), 3'(first_ship % 5));
    check("hit_ships_left", 32'(ships_left), 32'd2);
    shoot(3'(first_ship / 5), 3'(first_ship % 5));
    check("repeat_ships_left", 32'(ships_left), 32'd2);
    shoot(3'd5, 3'd0);
    shoot(3'd2, 3'd7);
    shoot(3'(first_miss / 5), 3'(first_miss % 5));
    random_until_sunk(40);

    // Requests in DONE must be ignored without a response.
    @(negedge clk);
    bus.shot_valid = 1'b1;
    bus.shot_i     = 3'd1;
    bus.shot_j     = 3'd1;
    repeat (4) begin
      @(negedge clk);
      check("done_ignores_shot", 32'(bus.shot_ready), 32'd0);
    end
    bus.shot_valid = 1'b0;

    place(3'd2, 1'b1);
    place(3'd0, 1'b1);
    place(3'd7, 1'b0);
    for (int n = 0; n < 6 && m_left > 0; n++)
      shoot(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));

    // Reset in the middle of placement.
    @(negedge clk);
    place_start = 1'b1;
    num_ships   = 3'd5;
    @(negedge clk);
    place_start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_fleet_ready", 32'(fleet_ready),    32'd0);
    check("midrst_ships_left",  32'(ships_left),     32'd0);
    check("midrst_ship_map",    32'(ship_map),       32'd0);
    check("midrst_shot_map",    32'(shot_map),       32'd0);
    check("midrst_shot_ready",  32'(bus.shot_ready), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_map", 32'(ship_map), 32'd0);
    place(3'd4, 1'b0);
    random_until_sunk(60);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
